draw_dog: RTL and testbench



---
 rtl/draw_dog.sv | 197 +++++++++++++++++++
 tb/tb_draw_dog.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/draw_dog.sv
// Dog sprite stage: walk/sniff/jump animation sequencer plus a 2-clk pixel
// pipeline that overlays the sprite ROM output with colour-key transparency.
module draw_dog #(
  parameter int          SPRITE_W    = 48,
  parameter int          SPRITE_H    = 53,
  parameter int          START_X     = 0,
  parameter int          STOP_X      = 200,
  parameter int          GROUND_Y    = 400,
  parameter int          WALK_STEP   = 4,
  parameter int          ANIM_DIV    = 4,
  parameter int          SNIFF_TICKS = 30,
  parameter int          JUMP_TICKS  = 20,
  parameter int          JUMP_STEP   = 3,
  parameter logic [11:0] TRANSP      = 12'hF0F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [10:0] in_hcount,
  input  logic [10:0] in_vcount,
  input  logic        in_hsync,
  input  logic        in_vsync,
  input  logic        in_hblnk,
  input  logic        in_vblnk,
  input  logic [11:0] in_rgb,
  output logic [12:0] rom_address,
  output logic [3:0]  dog_select,
  input  logic [11:0] rom_rgb,
  output logic [10:0] out_hcount,
  output logic [10:0] out_vcount,
  output logic        out_hsync,
  output logic        out_vsync,
  output logic        out_hblnk,
  output logic        out_vblnk,
  output logic [11:0] out_rgb,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, WALK, SNIFF, JUMP, HIDE} state_t;

  state_t      state, state_nxt;
  logic        vblnk_q, tick;
  logic [10:0] x_pos, y_pos;
  logic        visible;
  logic [7:0]  anim_cnt, tick_cnt;
  logic [11:0] x_step;

  always_comb begin
    tick   = in_vblnk & ~vblnk_q;
    x_step = {1'b0, x_pos} + 12'(WALK_STEP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vblnk_q <= 1'b0;
    else        vblnk_q <= in_vblnk;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = WALK;
      WALK:  if (tick && x_step >= 12'(STOP_X)) state_nxt = SNIFF;
      SNIFF: if (tick && tick_cnt == 8'(SNIFF_TICKS - 1)) state_nxt = JUMP;
      JUMP:  if (tick && tick_cnt == 8'(JUMP_TICKS - 1)) state_nxt = HIDE;
      HIDE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == HIDE);
  end

  // Position, frame index and counters only move on frame ticks; a start
  // arriving with a tick in IDLE enters WALK without consuming that tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_pos      <= 11'(START_X);
      y_pos      <= 11'(GROUND_Y);
      visible    <= 1'b0;
      dog_select <= '0;
      anim_cnt   <= '0;
      tick_cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          x_pos      <= 11'(START_X);
          y_pos      <= 11'(GROUND_Y);
          visible    <= 1'b1;
          dog_select <= '0;
          anim_cnt   <= '0;
          tick_cnt   <= '0;
        end
        WALK: if (tick) begin
          if (x_step >= 12'(STOP_X)) begin
            x_pos      <= 11'(STOP_X);
            dog_select <= 4'd4;
            tick_cnt   <= '0;
          end else begin
            x_pos <= x_step[10:0];
            if (anim_cnt == 8'(ANIM_DIV - 1)) begin
              anim_cnt   <= '0;
              dog_select <= (dog_select == 4'd3) ? 4'd0 : dog_select + 4'd1;
            end else begin
              anim_cnt <= anim_cnt + 8'd1;
            end
          end
        end
        SNIFF: if (tick) begin
          if (tick_cnt == 8'(SNIFF_TICKS - 1)) begin
            dog_select <= 4'd5;
            tick_cnt   <= '0;
          end else begin
            tick_cnt <= tick_cnt + 8'd1;
          end
        end
        JUMP: if (tick) begin
          y_pos    <= y_pos - 11'(JUMP_STEP);
          tick_cnt <= tick_cnt + 8'd1;
          if (tick_cnt + 8'd1 >= 8'(JUMP_TICKS / 2)) dog_select <= 4'd6;
        end
        HIDE: begin
          visible    <= 1'b0;
          dog_select <= '0;
          y_pos      <= 11'(GROUND_Y);
        end
        default: ;
      endcase
    end
  end

  logic        hit;
  logic [10:0] x_rel, y_rel;
  logic [12:0] addr_c;

  // 12-bit compares keep the right/bottom sprite edge from wrapping.
  always_comb begin
    hit = visible &&
          ({1'b0, in_hcount} >= {1'b0, x_pos}) &&
          ({1'b0, in_hcount} <= {1'b0, x_pos} + 12'(SPRITE_W - 1)) &&
          ({1'b0, in_vcount} >= {1'b0, y_pos}) &&
          ({1'b0, in_vcount} <= {1'b0, y_pos} + 12'(SPRITE_H - 1));
    x_rel  = in_hcount - x_pos;
    y_rel  = in_vcount - y_pos;
    addr_c = 13'(y_rel) * 13'(SPRITE_W) + 13'(x_rel);
  end

  logic [10:0] hcount_d, vcount_d;
  logic [3:0]  tim_d;
  logic [11:0] rgb_d, rgb_dd;
  logic        in_sprite, in_sprite_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_d    <= '0;
      vcount_d    <= '0;
      tim_d       <= '0;
      rgb_d       <= '0;
      in_sprite   <= 1'b0;
      rom_address <= '0;
      out_hcount  <= '0;
      out_vcount  <= '0;
      out_hsync   <= 1'b0;
      out_vsync   <= 1'b0;
      out_hblnk   <= 1'b0;
      out_vblnk   <= 1'b0;
      rgb_dd      <= '0;
      in_sprite_d <= 1'b0;
    end else begin
      hcount_d    <= in_hcount;
      vcount_d    <= in_vcount;
      tim_d       <= {in_hsync, in_vsync, in_hblnk, in_vblnk};
      rgb_d       <= in_rgb;
      in_sprite   <= hit;
      rom_address <= hit ? addr_c : '0;
      out_hcount  <= hcount_d;
      out_vcount  <= vcount_d;
      {out_hsync, out_vsync, out_hblnk, out_vblnk} <= tim_d;
      rgb_dd      <= rgb_d;
      in_sprite_d <= in_sprite;
    end
  end

  // rom_rgb arrives in the same cycle as the stage-2 registers, so the
  // final mux stays combinational to hold the 2-clk latency.
  always_comb begin
    out_rgb = (in_sprite_d && rom_rgb != TRANSP) ? rom_rgb : rgb_dd;
  end

endmodule

// File: tb/tb_draw_dog.sv
// Randomized bench for draw_dog: closed-form trajectory model (position and
// frame index as functions of ticks since start) plus a 2-deep pixel scoreboard.
module tb_draw_dog;

  localparam int SW = 48, SH = 53, START = 0, STOP = 200, GROUND = 400;
  localparam int STEP = 4, ANIM = 4, SN = 30, JT = 20, JSTEP = 3;
  localparam int WT = (STOP - START + STEP - 1) / STEP;
  localparam int TOTAL = WT + SN + JT;
  localparam logic [11:0] TRANSP = 12'hF0F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0, start = 1'b0;
  logic [10:0] in_hcount = '0, in_vcount = '0;
  logic        in_hsync = 1'b0, in_vsync = 1'b0, in_hblnk = 1'b0, in_vblnk = 1'b0;
  logic [11:0] in_rgb = '0, rom_rgb = '0;
  logic [12:0] rom_address;
  logic [3:0]  dog_select;
  logic [10:0] out_hcount, out_vcount;
  logic        out_hsync, out_vsync, out_hblnk, out_vblnk;
  logic [11:0] out_rgb;
  logic        busy, done;

  draw_dog dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_hcount(in_hcount), .in_vcount(in_vcount),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_hblnk(in_hblnk), .in_vblnk(in_vblnk),
    .in_rgb(in_rgb), .rom_address(rom_address), .dog_select(dog_select), .rom_rgb(rom_rgb),
    .out_hcount(out_hcount), .out_vcount(out_vcount),
    .out_hsync(out_hsync), .out_vsync(out_vsync), .out_hblnk(out_hblnk), .out_vblnk(out_vblnk),
    .out_rgb(out_rgb), .busy(busy), .done(done)
  );

  int rom_mode = 0;

  function automatic logic [11:0] rom_f(input logic [12:0] a);
    case (rom_mode)
      1:       return 12'hF0F;
      2:       return 12'h842;
      default: return {a[3:0], a[11:8], a[7:4]} ^ 12'h3C5;
    endcase
  endfunction

  always @(posedge clk) rom_rgb <= rom_f(rom_address);

  function automatic int fx(input int k);
    return (k >= WT) ? STOP : START + STEP * k;
  endfunction

  function automatic int fy(input int k);
    return (k <= WT + SN) ? GROUND : GROUND - JSTEP * (k - WT - SN);
  endfunction

  function automatic logic [3:0] fds(input int k);
    if (k < WT)                return 4'((k / ANIM) % 4);
    else if (k < WT + SN)      return 4'd4;
    else if (k - WT - SN < JT / 2) return 4'd5;
    else                       return 4'd6;
  endfunction

  typedef struct packed {
    logic        spr;
    logic [12:0] addr;
    logic [10:0] h, v;
    logic [3:0]  tim;
    logic [11:0] rgb;
  } pix_t;

  int   m_k = 0;
  bit   m_active = 0, m_hide = 0, m_vq = 0;
  pix_t p1 = '0, p2 = '0;

  function automatic pix_t model_pix(input bit vis, input int k);
    pix_t r;
    int h, v, x, y;
    h = int'(in_hcount); v = int'(in_vcount); x = fx(k); y = fy(k);
    r.spr  = vis && h >= x && h <= x + SW - 1 && v >= y && v <= y + SH - 1;
    r.addr = r.spr ? 13'((v - y) * SW + (h - x)) : 13'd0;
    r.h    = in_hcount;
    r.v    = in_vcount;
    r.tim  = {in_hsync, in_vsync, in_hblnk, in_vblnk};
    r.rgb  = in_rgb;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k <= 0; m_active <= 0; m_hide <= 0; m_vq <= 0; p1 <= '0; p2 <= '0;
    end else begin
      p2   <= p1;
      p1   <= model_pix(m_active || m_hide, m_k);
      m_vq <= in_vblnk;
      if (m_hide) m_hide <= 0;
      else if (!m_active) begin
        if (start) begin m_active <= 1; m_k <= 0; end
      end else if (in_vblnk && !m_vq) begin
        m_k <= m_k + 1;
        if (m_k + 1 == TOTAL) begin m_active <= 0; m_hide <= 1; end
      end
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [11:0] exp_rgb;
    exp_rgb = (p2.spr && rom_f(p2.addr) != TRANSP) ? rom_f(p2.addr) : p2.rgb;
    check_eq("out_rgb", out_rgb, exp_rgb);
    check_eq("out_hcount", out_hcount, p2.h);
    check_eq("out_vcount", out_vcount, p2.v);
    check_eq("out_timing", {out_hsync, out_vsync, out_hblnk, out_vblnk}, p2.tim);
    check_eq("rom_address", rom_address, p1.addr);
    check_eq("dog_select", dog_select, (m_active || m_hide) ? fds(m_k) : 4'd0);
    check_eq("busy", busy, m_active || m_hide);
    check_eq("done", done, m_hide);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive_pix();
    int x0, y0;
    x0 = fx(m_k); y0 = fy(m_k);
    if ($urandom_range(0, 1) == 1) begin
      in_hcount = 11'($urandom_range(0, 300));
      in_vcount = 11'($urandom_range(330, 470));
    end else begin
      in_hcount = 11'(((x0 >= 2) ? x0 - 2 : 0) + $urandom_range(0, SW + 3));
      in_vcount = 11'(((y0 >= 2) ? y0 - 2 : 0) + $urandom_range(0, SH + 3));
    end
    in_hsync = 1'($urandom); in_vsync = 1'($urandom); in_hblnk = 1'($urandom);
    in_rgb   = 12'($urandom);
  endtask

  task automatic frame(input bit extra_start);
    for (int i = 0; i < 10; i++) begin
      drive_pix(); in_vblnk = 1'b0; start = extra_start && (i == 5);
      step();
    end
    start = 1'b0; in_vblnk = 1'b1;
    drive_pix(); step();
    drive_pix(); step();
  endtask

  task automatic hold_pix(input int h, input int v, input logic [11:0] rgb);
    in_hcount = 11'(h); in_vcount = 11'(v); in_rgb = rgb; in_vblnk = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (3) step();
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_addr", rom_address, 13'd0);
    check_eq("rst_rgb", out_rgb, 12'd0);
    check_eq("rst_sel", dog_select, 4'd0);
    rst_n = 1'b1;

    // idle pass-through, random vblnk
    for (int i = 0; i < 40; i++) begin
      drive_pix(); in_vblnk = 1'($urandom); step();
    end
    check_eq("idle_busy", busy, 1'b0);

    // start coincident with vblnk rising edge
    in_vblnk = 1'b0; drive_pix(); step();
    start = 1'b1; in_vblnk = 1'b1; drive_pix(); step();
    start = 1'b0;
    for (int f = 0; f < 60 && m_k < WT; f++) frame(f % 7 == 3);
    check_eq("sniff_sel", dog_select, 4'd4);

    // sprite boundary at (200,400)
    hold_pix(200, 400, 12'h111); step();
    check_eq("addr_top_left", rom_address, 13'd0);
    hold_pix(247, 452, 12'h222); step();
    check_eq("addr_bot_right", rom_address, 13'd2543);
    hold_pix(248, 452, 12'h333); step();
    check_eq("addr_outside", rom_address, 13'd0);
    rom_mode = 1;
    hold_pix(220, 420, 12'h123); step(); step();
    check_eq("transp_pass", out_rgb, 12'h123);
    rom_mode = 2;
    hold_pix(220, 420, 12'h456); step(); step();
    check_eq("sprite_px", out_rgb, 12'h842);
    hold_pix(248, 420, 12'h789); step(); step();
    check_eq("right_edge_pass", out_rgb, 12'h789);
    rom_mode = 0;

    // sniff, jump, hide
    for (int f = 0; f < 80 && (m_active || m_hide); f++) frame(1'b0);
    repeat (4) begin drive_pix(); in_vblnk = 1'b0; step(); end
    check_eq("end_busy", busy, 1'b0);
    check_eq("end_sel", dog_select, 4'd0);

    // second run, abort mid-jump with reset
    start = 1'b1; drive_pix(); step();
    start = 1'b0;
    for (int f = 0; f < 120 && m_k < WT + SN + 5; f++) frame(1'b0);
    check_eq("jump_sel", dog_select, 4'd5);
    rst_n = 1'b0;
    #1;
    check_eq("abort_sel", dog_select, 4'd0);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_done", done, 1'b0);
    check_eq("abort_addr", rom_address, 13'd0);
    check_eq("abort_hcount", out_hcount, 11'd0);
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      drive_pix(); in_vblnk = 1'($urandom); step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
